// File: rtl/chrom_loader_if.sv
// Host stream and configuration bus of the chromosome loader.
// The host (master) drives the byte stream and abort; the loader (slave)
// drives ready, the active configuration and the status pulses.
interface chrom_loader_if #(
    parameter int NUM_LES      = 25,
    parameter int LE_BITS      = 13,
    parameter int NUM_OUTS     = 2,
    parameter int OUT_SEL_BITS = 5
);
    logic [7:0]                         in_data;
    logic                               in_valid;
    logic                               in_ready;
    logic                               load_abort;
    logic [NUM_LES*LE_BITS-1:0]         conf_les;
    logic [NUM_OUTS*OUT_SEL_BITS-1:0]   conf_outs;
    logic                               cfg_update;
    logic                               cfg_error;
    logic                               busy;

    modport master (
        output in_data, in_valid, load_abort,
        input  in_ready, conf_les, conf_outs, cfg_update, cfg_error, busy
    );

    modport slave (
        input  in_data, in_valid, load_abort,
        output in_ready, conf_les, conf_outs, cfg_update, cfg_error, busy
    );
endinterface

// File: rtl/chrom_loader.sv
// Chromosome loader: deserialises a framed byte stream (header, payload,
// XOR checksum) into a shadow register and commits it atomically onto the
// logic-element configuration buses, so the array never sees a partial load.
module chrom_loader #(
    parameter int         NUM_LES      = 25,
    parameter int         LE_BITS      = 13,
    parameter int         NUM_OUTS     = 2,
    parameter int         OUT_SEL_BITS = 5,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input logic          clk,
    input logic          rst,
    chrom_loader_if.slave bus
);
    localparam int LES_W      = NUM_LES * LE_BITS;
    localparam int OUTS_W     = NUM_OUTS * OUT_SEL_BITS;
    localparam int TOTAL_BITS = LES_W + OUTS_W;
    localparam int NUM_BYTES  = (TOTAL_BITS + 7) / 8;
    localparam int CNT_W      = $clog2(NUM_BYTES);
    localparam int IDX_W      = CNT_W + 3;

    typedef enum logic [1:0] {StIdle, StPayload, StCsum, StCommit} state_t;

    state_t                 state;
    logic [TOTAL_BITS-1:0]  shadow;
    logic [TOTAL_BITS-1:0]  shadow_wr;
    logic [CNT_W-1:0]       byte_cnt;
    logic [7:0]             run_xor;
    logic [LES_W-1:0]       conf_les;
    logic [OUTS_W-1:0]      conf_outs;
    logic                   cfg_update;
    logic                   cfg_error;
    logic                   busy;
    logic                   in_ready;
    logic                   xfer;
    logic [IDX_W-1:0]       bit_idx;

    assign xfer = bus.in_valid && in_ready;

    assign bus.in_ready   = in_ready;
    assign bus.conf_les   = conf_les;
    assign bus.conf_outs  = conf_outs;
    assign bus.cfg_update = cfg_update;
    assign bus.cfg_error  = cfg_error;
    assign bus.busy       = busy;

    // Shadow with the incoming byte merged at the current byte slot; the
    // padding bits beyond TOTAL_BITS have no storage and are skipped.
    always_comb begin
        shadow_wr = shadow;
        bit_idx   = '0;
        for (int b = 0; b < 8; b++) begin
            bit_idx = {byte_cnt, 3'(b)};
            if (bit_idx < IDX_W'(TOTAL_BITS)) begin
                shadow_wr[bit_idx] = bus.in_data[b];
            end
        end
    end

    // Frame FSM with registered ready/busy/pulse outputs and the commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            shadow     <= '0;
            byte_cnt   <= '0;
            run_xor    <= '0;
            conf_les   <= '0;
            conf_outs  <= '0;
            cfg_update <= 1'b0;
            cfg_error  <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            cfg_update <= 1'b0;
            cfg_error  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (xfer && bus.in_data == HEADER) begin
                        state    <= StPayload;
                        byte_cnt <= '0;
                        run_xor  <= '0;
                        busy     <= 1'b1;
                    end
                end
                StPayload: begin
                    // Abort wins over a concurrent byte, which is discarded.
                    if (bus.load_abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        shadow  <= shadow_wr;
                        run_xor <= run_xor ^ bus.in_data;
                        if (byte_cnt == CNT_W'(NUM_BYTES - 1)) begin
                            state <= StCsum;
                        end
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                StCsum: begin
                    if (bus.load_abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (xfer) begin
                        if (bus.in_data == run_xor) begin
                            state    <= StCommit;
                            in_ready <= 1'b0;
                        end else begin
                            state     <= StIdle;
                            busy      <= 1'b0;
                            cfg_error <= 1'b1;
                        end
                    end
                end
                StCommit: begin
                    conf_les   <= shadow[LES_W-1:0];
                    conf_outs  <= shadow[TOTAL_BITS-1 -: OUTS_W];
                    cfg_update <= 1'b1;
                    state      <= StIdle;
                    busy       <= 1'b0;
                    in_ready   <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_chrom_loader.sv
// Randomised bench for chrom_loader: frames are built as byte arrays and the
// expected configuration is unpacked from them by the flat-vector bit order.
module tb_chrom_loader;
    localparam int         LES_W      = 25 * 13;
    localparam int         OUTS_W     = 2 * 5;
    localparam int         TOTAL_BITS = LES_W + OUTS_W;
    localparam int         NUM_BYTES  = (TOTAL_BITS + 7) / 8;
    localparam logic [7:0] HEADER     = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chrom_loader_if bus ();

    chrom_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_upd   = 0;
    int n_err   = 0;
    int n_nrdy  = 0;

    logic [LES_W-1:0]  exp_les  = '0;
    logic [OUTS_W-1:0] exp_outs = '0;
    logic [7:0]        payload [NUM_BYTES];

    task automatic check(input string tag, input logic [LES_W-1:0] got,
                         input logic [LES_W-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Pulse and ready-low cycle counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cfg_update) n_upd++;
            if (bus.cfg_error) n_err++;
            if (!bus.in_ready) n_nrdy++;
        end
    end

    // Reference: flat vector is the payload bytes concatenated LSB first.
    task automatic model_commit();
        logic [NUM_BYTES*8-1:0] flat;
        for (int k = 0; k < NUM_BYTES; k++) flat[k*8 +: 8] = payload[k];
        exp_les  = flat[LES_W-1:0];
        exp_outs = flat[TOTAL_BITS-1:LES_W];
    endtask

    task automatic random_payload();
        for (int k = 0; k < NUM_BYTES; k++) payload[k] = 8'($urandom_range(255, 0));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit abort);
        bit done = 0;
        bit rdy;
        int waited = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
                bus.in_valid   = 1'b0;
                bus.load_abort = 1'b0;
            end
        end
        while (!done) begin
            @(negedge clk);
            bus.in_data    = b;
            bus.in_valid   = 1'b1;
            bus.load_abort = abort;
            rdy = bus.in_ready;
            @(posedge clk);
            done = rdy;
            waited++;
            if (!done && waited > 20) begin
                check("ready_timeout", 1'b0, 1'b1);
                done = 1;
            end
        end
    endtask

    task automatic run_frame(input string tag, input bit gaps, input logic [7:0] delta);
        logic [7:0] cs = '0;
        int upd0 = n_upd;
        int err0 = n_err;
        int nrdy0 = n_nrdy;
        for (int k = 0; k < NUM_BYTES; k++) cs ^= payload[k];
        cs ^= delta;
        send_byte(HEADER, gaps, 1'b0);
        for (int k = 0; k < NUM_BYTES; k++) send_byte(payload[k], gaps, 1'b0);
        send_byte(cs, gaps, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (delta == 8'h00) begin
            check({tag, "_commit_ready"}, bus.in_ready, 1'b0);
            check({tag, "_commit_busy"}, bus.busy, 1'b1);
            check({tag, "_early_upd"}, bus.cfg_update, 1'b0);
            @(negedge clk);
            model_commit();
            check({tag, "_upd"}, bus.cfg_update, 1'b1);
            check({tag, "_busy_fall"}, bus.busy, 1'b0);
            check({tag, "_ready_back"}, bus.in_ready, 1'b1);
            check({tag, "_les"}, bus.conf_les, exp_les);
            check({tag, "_outs"}, bus.conf_outs, exp_outs);
            @(negedge clk);
            check({tag, "_upd_end"}, bus.cfg_update, 1'b0);
        end else begin
            check({tag, "_err"}, bus.cfg_error, 1'b1);
            check({tag, "_err_busy"}, bus.busy, 1'b0);
            @(negedge clk);
            check({tag, "_err_end"}, bus.cfg_error, 1'b0);
            check({tag, "_keep_les"}, bus.conf_les, exp_les);
            check({tag, "_keep_outs"}, bus.conf_outs, exp_outs);
        end
        #1;
        check({tag, "_n_upd"}, LES_W'(n_upd - upd0), (delta == 8'h00) ? 1 : 0);
        check({tag, "_n_err"}, LES_W'(n_err - err0), (delta != 8'h00) ? 1 : 0);
        check({tag, "_n_nrdy"}, LES_W'(n_nrdy - nrdy0), (delta == 8'h00) ? 1 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int upd0;
        int err0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.load_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_les", bus.conf_les, '0);
        check("rst_outs", bus.conf_outs, '0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.in_ready, 1'b1);
        check("rst_pulses", {bus.cfg_update, bus.cfg_error}, 2'b00);
        rst = 1'b0;

        // Directed frame: byte0=0x07, byte40=0x60, checksum 0x67.
        for (int k = 0; k < NUM_BYTES; k++) payload[k] = 8'h00;
        payload[0]  = 8'h07;
        payload[40] = 8'h60;
        run_frame("dir", 1'b0, 8'h00);
        check("dir_le0", bus.conf_les[12:0], 13'h0007);

        // Same payload, checksum 0x66.
        run_frame("bad_cs", 1'b0, 8'h01);

        // Garbage before header is dropped.
        send_byte(8'h00, 1'b0, 1'b0);
        #1 check("garb0_busy", bus.busy, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b0);
        #1 check("garb1_busy", bus.busy, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        #1 check("garb2_busy", bus.busy, 1'b0);
        random_payload();
        run_frame("garb_frame", 1'b0, 8'h00);

        // Stalls with header values inside the payload.
        random_payload();
        payload[3]  = HEADER;
        payload[17] = HEADER;
        payload[41] = HEADER;
        run_frame("gaps", 1'b1, 8'h00);

        // Abort after payload byte 20 with a concurrent byte.
        upd0 = n_upd;
        err0 = n_err;
        send_byte(HEADER, 1'b0, 1'b0);
        for (int k = 0; k <= 20; k++) send_byte(8'($urandom_range(255, 0)), 1'b0, 1'b0);
        send_byte(8'($urandom_range(255, 0)), 1'b0, 1'b1);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.load_abort = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("abort_upd", LES_W'(n_upd - upd0), 0);
        check("abort_err", LES_W'(n_err - err0), 0);
        check("abort_les", bus.conf_les, exp_les);
        random_payload();
        run_frame("post_abort", 1'b0, 8'h00);

        // Asynchronous reset mid-payload.
        send_byte(HEADER, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) send_byte(8'($urandom_range(255, 0)), 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_les  = '0;
        exp_outs = '0;
        check("arst_les", bus.conf_les, exp_les);
        check("arst_outs", bus.conf_outs, exp_outs);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_ready", bus.in_ready, 1'b1);
        #1 rst = 1'b0;
        random_payload();
        run_frame("post_rst", 1'b0, 8'h00);

        // Random frames, some with corrupted checksums.
        for (int i = 0; i < 4; i++) begin
            random_payload();
            run_frame("rnd", 1'($urandom_range(1, 0)),
                      ($urandom_range(2, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
